// File: rtl/mul_pkg.sv
// Shared constants, state encoding and sign helpers for the sequential multiplier.
package mul_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_W     = 64;
    localparam int MAX_ACC_W = 2 * MAX_W;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Magnitude of a sign-extended operand; the most negative N-bit value maps
    // to 2^(N-1), which still fits in N unsigned bits once truncated.
    function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] v);
        return v[MAX_W-1] ? -v : v;
    endfunction

    // Two's-complement negation of a zero-extended product; caller truncates to 2N.
    function automatic logic [MAX_ACC_W-1:0] neg_2n(input logic [MAX_ACC_W-1:0] v);
        return -v;
    endfunction

endpackage

// File: rtl/mul_seq_nat_int_if.sv
// Operand and result handshake bundle for the sequential multiplier.
interface mul_seq_nat_int_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           int_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] m;
    logic           busy;

    modport master (
        output in_valid, x, y, int_mode, out_ready,
        input  in_ready, out_valid, m, busy
    );

    modport slave (
        input  in_valid, x, y, int_mode, out_ready,
        output in_ready, out_valid, m, busy
    );

endinterface

// File: rtl/mul_add_row.sv
// One N x 4 digit product plus an N-bit addend; reused every compute cycle.
module mul_add_row
    import mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         x,
    input  logic [DIGIT_W-1:0]   y,
    input  logic [N-1:0]         c,
    output logic [N+DIGIT_W-1:0] p
);

    localparam int RW = N + DIGIT_W;

    // (2^N-1)*15 + (2^N-1) < 2^(N+4), so the row never overflows.
    always_comb begin
        p = RW'(x) * RW'(y) + RW'(c);
    end

endmodule

// File: rtl/mul_seq_nat_int.sv
// Iterative N x N multiplier, one 4-bit digit of y per clock, natural or
// two's-complement operands selected per operation.
module mul_seq_nat_int
    import mul_pkg::*;
#(
    parameter int N = 8
) (
    input logic              clock,
    input logic              reset,
    mul_seq_nat_int_if.slave bus
);

    localparam int D     = N / DIGIT_W;
    localparam int W2    = 2 * N;
    localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     ax_q, ax_d;
    logic [N-1:0]     ay_q, ay_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    m_q, m_d;

    logic [N+DIGIT_W-1:0] row_sum;
    logic [W2-1:0]        acc_step;
    logic [N-1:0]         x_in, y_in;
    logic                 neg_in;

    // Upper half of the accumulator is the addend; y is consumed from its low digit.
    mul_add_row #(.N(N)) u_row (
        .x (ax_q),
        .y (ay_q[DIGIT_W-1:0]),
        .c (acc_q[W2-1:N]),
        .p (row_sum)
    );

    // Fold the new row into the top and shift one digit right; the digit shifted
    // out of the bottom is always one of the zeros the low half started with.
    always_comb begin
        acc_step = W2'({row_sum, acc_q[N-1:0]} >> DIGIT_W);
    end

    // Operand conditioning at accept: magnitudes plus a result sign in integer mode.
    always_comb begin
        x_in   = bus.x;
        y_in   = bus.y;
        neg_in = 1'b0;
        if (bus.int_mode) begin
            x_in   = N'(abs_n(MAX_W'(signed'(bus.x))));
            y_in   = N'(abs_n(MAX_W'(signed'(bus.y))));
            // A zero operand forces a positive result so -0 never arises.
            neg_in = (bus.x[N-1] ^ bus.y[N-1]) & (|bus.x) & (|bus.y);
        end
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    ax_d    = x_in;
                    ay_d    = y_in;
                    neg_d   = neg_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                ay_d  = ay_q >> DIGIT_W;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    m_d     = neg_q ? W2'(neg_2n(MAX_ACC_W'(acc_step))) : acc_step;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ax_q    <= '0;
            ay_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_CALC);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.m         = m_q;

endmodule

// File: tb/tb_mul_seq_nat_int.sv
// Self-checking bench: directed cases at N=8, random cases at N=16 and N=32.
module tb_mul_seq_nat_int;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mul_seq_nat_int_if #(.N(8))  if8 ();
    mul_seq_nat_int_if #(.N(16)) if16 ();
    mul_seq_nat_int_if #(.N(32)) if32 ();

    mul_seq_nat_int #(.N(8))  dut8  (.clock(clock), .reset(reset), .bus(if8));
    mul_seq_nat_int #(.N(16)) dut16 (.clock(clock), .reset(reset), .bus(if16));
    mul_seq_nat_int #(.N(32)) dut32 (.clock(clock), .reset(reset), .bus(if32));

    task automatic drive_in(input int w, input logic v, input logic [63:0] xa,
                            input logic [63:0] ya, input logic im);
        case (w)
            8: begin
                if8.in_valid = v; if8.x = xa[7:0]; if8.y = ya[7:0]; if8.int_mode = im;
            end
            16: begin
                if16.in_valid = v; if16.x = xa[15:0]; if16.y = ya[15:0]; if16.int_mode = im;
            end
            default: begin
                if32.in_valid = v; if32.x = xa[31:0]; if32.y = ya[31:0]; if32.int_mode = im;
            end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            8:       if8.out_ready = r;
            16:      if16.out_ready = r;
            default: if32.out_ready = r;
        endcase
    endtask

    function automatic logic get_ov(input int w);
        case (w)
            8:       return if8.out_valid;
            16:      return if16.out_valid;
            default: return if32.out_valid;
        endcase
    endfunction

    function automatic logic [127:0] get_m(input int w);
        case (w)
            8:       return 128'(if8.m);
            16:      return 128'(if16.m);
            default: return 128'(if32.m);
        endcase
    endfunction

    // Reference: plain arithmetic on the operand values, reduced modulo 2^(2w).
    function automatic logic [127:0] ref_mul(input int w, input logic [63:0] xa,
                                             input logic [63:0] ya, input logic im);
        logic [127:0] mask;
        logic [63:0]  wmask;
        longint       sx, sy;
        mask  = (128'd1 << (2 * w)) - 128'd1;
        wmask = (64'd1 << w) - 64'd1;
        if (!im) begin
            return (128'(xa & wmask) * 128'(ya & wmask)) & mask;
        end
        sx = longint'(xa << (64 - w)) >>> (64 - w);
        sy = longint'(ya << (64 - w)) >>> (64 - w);
        return 128'(sx * sy) & mask;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] r;
        logic [63:0] wmask;
        r     = {$urandom, $urandom};
        wmask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1 << (w - 1);
            2:       return wmask;
            3:       return 64'd1;
            default: return r & wmask;
        endcase
    endfunction

    // One full transaction with out_ready high; lat = edges from accept to out_valid,
    // -1 if out_valid never arrives. Entered and left at #1 after a rising edge.
    task automatic run_op(input int w, input logic [63:0] xa, input logic [63:0] ya,
                          input logic im, output logic [127:0] got, output int lat);
        got = '0;
        lat = -1;
        drive_in(w, 1'b1, xa, ya, im);
        set_ordy(w, 1'b1);
        @(posedge clock); #1;
        drive_in(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, ~im);
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clock); #1;
            if (get_ov(w)) begin
                lat = i;
                got = get_m(w);
            end
        end
        if (lat >= 0) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        drive_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
        drive_in(16, 1'b0, 64'd0, 64'd0, 1'b0);
        drive_in(32, 1'b0, 64'd0, 64'd0, 1'b0);
        set_ordy(8, 1'b0); set_ordy(16, 1'b0); set_ordy(32, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", if8.in_ready); end
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", if8.out_valid); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if8.busy); end
        checks++; if (if8.m !== 16'h0000) begin errors++; $display("FAIL reset_m got %h want 0000", if8.m); end
        checks++; if (if32.m !== 64'h0) begin errors++; $display("FAIL reset_m32 got %h want 0", if32.m); end
        reset = 1'b0;
    endtask

    task automatic test_natural();
        logic [7:0]   xs [3];
        logic [7:0]   ys [3];
        logic [15:0]  es [3];
        logic [127:0] got;
        int           lat;
        xs = '{8'd200, 8'd255, 8'd0};
        ys = '{8'd150, 8'd255, 8'd77};
        es = '{16'h7530, 16'hFE01, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            run_op(8, 64'(xs[i]), 64'(ys[i]), 1'b0, got, lat);
            checks++; if (got !== 128'(es[i])) begin errors++; $display("FAIL nat_m[%0d] got %h want %h", i, got, es[i]); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL nat_latency[%0d] got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_integer();
        logic [7:0]   xs [3];
        logic [7:0]   ys [3];
        logic [15:0]  es [3];
        logic [127:0] got;
        int           lat;
        xs = '{8'hFD, 8'h80, 8'h80};
        ys = '{8'h05, 8'h80, 8'h7F};
        es = '{16'hFFF1, 16'h4000, 16'hC080};
        for (int i = 0; i < 3; i++) begin
            run_op(8, 64'(xs[i]), 64'(ys[i]), 1'b1, got, lat);
            checks++; if (got !== 128'(es[i])) begin errors++; $display("FAIL int_m[%0d] got %h want %h", i, got, es[i]); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL int_latency[%0d] got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic seen;
        seen = 1'b0;
        drive_in(8, 1'b1, 64'd100, 64'd3, 1'b0);
        set_ordy(8, 1'b0);
        @(posedge clock); #1;
        drive_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clock); #1;
            seen = if8.out_valid;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_out_valid_timeout got 0 want 1"); end
        for (int i = 0; i < 10; i++) begin
            drive_in(8, i[0], 64'($urandom), 64'($urandom), 1'b1);
            @(posedge clock); #1;
            checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, if8.out_valid); end
            checks++; if (if8.m !== 16'h012C) begin errors++; $display("FAIL bp_hold_m[%0d] got %h want 012c", i, if8.m); end
            checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, if8.in_ready); end
            checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL bp_busy[%0d] got %b want 0", i, if8.busy); end
        end
        drive_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
        set_ordy(8, 1'b1);
        @(posedge clock); #1;
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", if8.out_valid); end
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", if8.in_ready); end
        @(posedge clock); #1;
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL bp_no_stray_op got %b want 0", if8.busy); end
    endtask

    task automatic test_reset_mid();
        logic         seen;
        logic [127:0] got;
        int           lat;
        drive_in(8, 1'b1, 64'd250, 64'd250, 1'b0);
        set_ordy(8, 1'b1);
        @(posedge clock); #1;
        drive_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", if8.busy); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", if8.in_ready); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", if8.busy); end
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", if8.out_valid); end
        checks++; if (if8.m !== 16'h0000) begin errors++; $display("FAIL mid_m got %h want 0000", if8.m); end
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (if8.out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_stray_valid got 1 want 0"); end
        run_op(8, 64'd12, 64'd13, 1'b0, got, lat);
        checks++; if (got !== 128'd156) begin errors++; $display("FAIL mid_next_m got %0d want 156", got); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_next_latency got %0d want 2", lat); end
    endtask

    task automatic test_random(input int w);
        logic [63:0]  xa, ya;
        logic         im;
        logic [127:0] got, exp;
        int           lat;
        for (int i = 0; i < 1000; i++) begin
            xa = pick(w);
            ya = pick(w);
            im = 1'($urandom_range(0, 1));
            run_op(w, xa, ya, im, got, lat);
            exp = ref_mul(w, xa, ya, im);
            checks++; if (got !== exp) begin errors++; $display("FAIL rand%0d_m x=%h y=%h int=%b got %h want %h", w, xa, ya, im, got, exp); end
            checks++; if (lat !== w / 4) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", w, lat, w / 4); end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clock); #1;
        test_natural();
        test_integer();
        test_backpressure();
        test_reset_mid();
        test_random(16);
        test_random(32);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_seq_nat_int.md
Name: mul_seq_nat_int

Overview:
- Iterative N-bit x N-bit multiplier producing a 2N-bit product. Processes one 4-bit digit of y per clock.
- Selectable natural or two's-complement (integer) mode, chosen per operation.
- Generalises the combinational 8-bit digit-product multiplier to any width that is a multiple of 4, trading area for latency.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- N, 8, operand width in bits; multiple of 4, range 4..64.
- D (derived, not overridable), N/4, number of y digits = compute cycles.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands x, y, int_mode are valid.
- in_ready  output  1  block can accept operands.
- x  input  N  multiplicand.
- y  input  N  multiplier.
- int_mode  input  1  0 = natural operands; 1 = two's-complement operands.
- out_valid  output  1  m holds a completed product.
- out_ready  input  1  consumer accepts m.
- m  output  2N  product: natural, or two's complement when int_mode was 1.
- busy  output  1  high in CALC.

Behaviour:
- Reset values (asynchronous, effective immediately, holds while reset=1):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, m=0.
  - accumulator, digit counter and latched operands = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch x, y, int_mode, then go to CALC with counter=0.
  - Natural mode latches the operands as is.
  - Integer mode latches |x|, |y| as N-bit naturals plus neg = sign(x) XOR sign(y).
  - |-2^(N-1)| = 2^(N-1) fits in N unsigned bits; no overflow.
- CALC:
  - in_ready=0, busy=1.
  - Each edge: acc = acc + (ax * ay_digit[counter]) << (4*counter); counter++.
  - Each step is one N x 4 digit product plus addend.
  - After the edge with counter = D-1, go to DONE and load m = neg ? -acc : acc (2N-bit two's complement).
  - Natural mode forces neg=0.
- DONE:
  - out_valid=1; m stable until the handshake completes.
  - On an edge with out_ready=1, go to IDLE; out_valid drops.
- Latency: out_valid rises exactly D edges after the accepting edge.
- Throughput: one product per D+2 cycles minimum. The block does not accept new operands in DONE (in_ready=0).
- Back-pressure: out_ready may stay low indefinitely; m and out_valid hold unchanged.
- in_valid while not in_ready is ignored. Operand inputs are sampled only on the accepting edge; later changes have no effect.
- Width rules:
  - The natural product always fits 2N bits: max (2^N-1)^2 < 2^(2N).
  - The integer product always fits 2N signed bits: max magnitude 2^(2N-2).
  - There is no overflow flag.
- Zero operands: the full D cycles still execute; m=0 and the sign is forced positive. In integer mode -0 never appears, because -0 = 0.
- Reset asserted mid-CALC or mid-DONE: the operation is abandoned, all outputs return to reset values, and no partial product ever appears with out_valid=1.

Decomposition:
- Shared package mul_pkg:
  - DIGIT_W = 4.
  - State encoding constants S_IDLE, S_CALC, S_DONE.
  - Helper function for N-bit absolute value / 2N-bit negation.
- Sub-module mul_add_row:
  - Parameter N. Inputs: N-bit x, 4-bit digit y, N-bit addend c. Output: N+4-bit x*y + c.
  - Purely combinational; generalises the 4x4 digit multiply-add to an N x 4 row.
  - Instantiated once and reused every CALC cycle. The accumulator's upper N bits feed c, and the register shifts right by 4 each cycle.
- Top module: FSM, operand/accumulator registers, sign handling, handshakes.

Test Plan:
- N=8, natural, x=200, y=150, out_ready=1 -> out_valid exactly 2 edges after accept, m=0x7530 (30000).
- N=8, natural, x=255, y=255 -> m=0xFE01. Then x=0, y=77 -> m=0x0000.
- N=8, int_mode=1:
  - x=-3 (0xFD), y=5 -> m=0xFFF1 (-15).
  - x=-128, y=-128 -> m=0x4000.
  - x=-128, y=127 -> m=0xC080.
- Back-pressure: hold out_ready=0 for 10 cycles -> m and out_valid stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next edge, in_ready=1.
- Reset mid-CALC, asserted between clock edges -> outputs go to reset values immediately, no out_valid afterward. A next operation, N=8 with 12*13, gives m=156.
- N=16 and N=32 random natural and integer operands, 1000 each, against a reference model -> exact match. Latency equals 4 and 8 edges respectively.
